capture_pkt_sched: RTL
======================

Name: capture_pkt_sched

Overview:
- Sequences one ADC capture and its packetised readout inside the capture datapath.
- On a start pulse it fills the capture buffer with one packet's worth of 18-bit ADC samples. It then replays the buffer as framed packets at a configured beat rate, with idle spacing between packets.
- It sits between the top regfile (configuration, start/again) and the capture memory and pad-output packet path.

Parameters:
- DW, 18, ADC sample width.
- AW, 11, capture memory address width; 2^AW must be >= 1728.
- IDLE_W, 8, idle-length field width.
- CNT_W, 16, packet-count width.

Ports:
- clk_100m  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_en  in  1  block enable; 0 aborts and holds IDLE.
- cfg_capture_mode  in  1  0 = continuous replay, 1 = single packet then DONE.
- cfg_data_length  in  2  packet length code: 00=216, 01=432, 10=864, 11=1728 words.
- cfg_gap  in  4  idle cycles between beats; beat period is gap+1.
- cfg_idle_length  in  IDLE_W  idle cycles between packets.
- capture_start  in  1  single-cycle start pulse.
- capture_again  in  1  single-cycle re-capture pulse.
- adc_vld  in  1  ADC sample valid.
- adc_data  in  DW  ADC sample.
- mem_wr_en  out  1  capture memory write enable.
- mem_wr_addr  out  AW  write address.
- mem_wr_data  out  DW  write data.
- mem_rd_en  out  1  memory read enable; data returns 1 cycle later.
- mem_rd_addr  out  AW  read address.
- mem_rd_data  in  DW  read data.
- pkt_vld  out  1  packet beat valid.
- pkt_sop  out  1  first beat of a packet.
- pkt_eop  out  1  last beat of a packet.
- pkt_data  out  DW  packet beat data.
- busy  out  1  high in CAPTURE, SEND and IDLE_GAP.
- done  out  1  high in DONE.
- pkt_cnt  out  CNT_W  packets sent since the last capture; saturates.

Behaviour:
- Reset: every output is 0; state is IDLE.
- Configuration: all cfg fields are latched into shadow registers on the accepted start/again pulse. Mid-run configuration changes take effect only at the next capture.
- Packet length L is decoded from the shadow copy of cfg_data_length.
- IDLE:
  - capture_start with cfg_en=1 -> CAPTURE.
  - The write counter and pkt_cnt clear.
- CAPTURE:
  - Each cycle with adc_vld=1: mem_wr_en=1, mem_wr_addr=wcnt, mem_wr_data=adc_data, wcnt++.
  - adc_vld=0 pauses writing; there is no timeout.
  - The write at wcnt=L-1 moves to SEND the next cycle with rcnt=0.
- SEND:
  - mem_rd_en is issued on the first SEND cycle and then every gap+1 cycles, with mem_rd_addr=rcnt.
  - One cycle after each mem_rd_en: pkt_vld=1 and pkt_data=mem_rd_data.
  - pkt_sop is high with beat 0; pkt_eop is high with beat L-1.
  - Exactly L beats are sent.
  - pkt_cnt increments on the eop beat and saturates at all-ones.
- After the eop beat:
  - idle_length>0 -> IDLE_GAP.
  - idle_length=0 -> next state immediately.
- IDLE_GAP: counts idle_length cycles; pkt_vld stays 0 throughout. The next state is:
  - mode 0 -> SEND, rcnt=0, same buffer replayed;
  - mode 1 -> DONE.
- DONE:
  - capture_again or capture_start -> CAPTURE; pkt_cnt and wcnt clear.
  - Otherwise it holds with done=1.
- Simultaneous start and again: treated as a single event.
- Start/again received in CAPTURE, SEND or IDLE_GAP: ignored.
- Mode 0 never reaches DONE; only cfg_en=0 stops it.
- cfg_en=0 in any state:
  - next cycle -> IDLE;
  - mem_*_en, pkt_vld, pkt_sop and pkt_eop drop to 0 in that same next cycle;
  - a partially sent packet is truncated with no eop;
  - pkt_cnt holds its value until the next start.
- rst asserted mid-operation: immediate return to reset values.
- Latency: capture_start to first mem_wr_en is 1 cycle when adc_vld=1.

Test Plan:
- Code 00, gap=0, idle=4, mode=1; start; adc_vld=1 with a ramp 0..215 -> 216 writes at addr 0..215. Then 216 consecutive pkt_vld beats, data 0..215, sop on beat 0, eop on beat 215. 4 idle cycles, then DONE; pkt_cnt=1.
- Code 01, gap=3, idle=0, mode=0 -> beats every 4 cycles, 432 per packet. Packets back-to-back with eop followed by the next read 1 cycle later. pkt_cnt=3 after 3 packets.
- adc_vld toggling 1-0 during capture -> only valid samples written, addresses contiguous, SEND starts after the 864th write (code 10).
- cfg_en dropped mid-SEND (beat 100, code 11) -> next cycle IDLE, pkt_vld=0, no eop, busy=0. A subsequent start recaptures from addr 0.
- capture_start during SEND ignored; capture_again in DONE -> new capture with updated cfg_data_length, and pkt_cnt cleared.
- cfg_gap changed during SEND -> beat spacing unchanged until the next capture; start and again in the same cycle -> exactly one capture.

Source files
------------

// File: rtl/capture_pkt_sched.sv
// Capture sequencer: fills the capture buffer with one packet of ADC samples,
// then replays it as framed packets with programmable beat and packet spacing.
module capture_pkt_sched #(
  parameter int DW     = 18,
  parameter int AW     = 11,
  parameter int IDLE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_capture_mode,
  input  logic [1:0]        cfg_data_length,
  input  logic [3:0]        cfg_gap,
  input  logic [IDLE_W-1:0] cfg_idle_length,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic              adc_vld,
  input  logic [DW-1:0]     adc_data,
  output logic              mem_wr_en,
  output logic [AW-1:0]     mem_wr_addr,
  output logic [DW-1:0]     mem_wr_data,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [DW-1:0]     mem_rd_data,
  output logic              pkt_vld,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [DW-1:0]     pkt_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CAPTURE  = 3'd1;
  localparam logic [2:0] ST_SEND     = 3'd2;
  localparam logic [2:0] ST_IDLE_GAP = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // One extra bit so the read counter can sit at L (all reads issued).
  localparam int CW = AW + 1;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [IDLE_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              mode_q, mode_d;
  logic [1:0]        len_q, len_d;
  logic [3:0]        gap_q, gap_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              pkt_vld_q, pkt_vld_d;
  logic              pkt_sop_q, pkt_sop_d;
  logic              pkt_eop_q, pkt_eop_d;

  logic [CW-1:0]     len_words;
  logic              wr_fire;
  logic              rd_fire;
  logic              trig;

  always_comb begin
    case (len_q)
      2'b00:   len_words = CW'(216);
      2'b01:   len_words = CW'(432);
      2'b10:   len_words = CW'(864);
      default: len_words = CW'(1728);
    endcase
  end

  assign wr_fire = (state_q == ST_CAPTURE) && adc_vld;
  assign rd_fire = (state_q == ST_SEND) && (rcnt_q != len_words) && (gcnt_q == 4'd0);
  assign trig    = capture_start | capture_again;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    gcnt_d    = gcnt_q;
    icnt_d    = icnt_q;
    pkt_cnt_d = pkt_cnt_q;
    mode_d    = mode_q;
    len_d     = len_q;
    gap_d     = gap_q;
    idle_d    = idle_q;
    // A read issued while the block is being disabled never becomes a beat.
    pkt_vld_d = rd_fire && cfg_en;
    pkt_sop_d = rd_fire && cfg_en && (rcnt_q == '0);
    pkt_eop_d = rd_fire && cfg_en && (rcnt_q == len_words - 1'b1);

    if (pkt_eop_q && (pkt_cnt_q != '1)) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (capture_start && cfg_en) begin
          state_d   = ST_CAPTURE;
          wcnt_d    = '0;
          pkt_cnt_d = '0;
          mode_d    = cfg_capture_mode;
          len_d     = cfg_data_length;
          gap_d     = cfg_gap;
          idle_d    = cfg_idle_length;
        end
      end
      ST_CAPTURE: begin
        if (adc_vld) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == len_words - 1'b1) begin
            state_d = ST_SEND;
            rcnt_d  = '0;
            gcnt_d  = 4'd0;
          end
        end
      end
      ST_SEND: begin
        if (rd_fire) begin
          rcnt_d = rcnt_q + 1'b1;
          gcnt_d = gap_q;
        end else if (gcnt_q != 4'd0) begin
          gcnt_d = gcnt_q - 1'b1;
        end
        // The eop beat is on the wire this cycle; decide what follows it.
        if (pkt_eop_q) begin
          if (idle_q != '0) begin
            state_d = ST_IDLE_GAP;
            icnt_d  = idle_q - 1'b1;
          end else if (mode_q) begin
            state_d = ST_DONE;
          end else begin
            rcnt_d = '0;
            gcnt_d = 4'd0;
          end
        end
      end
      ST_IDLE_GAP: begin
        if (icnt_q == '0) begin
          if (mode_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
            rcnt_d  = '0;
            gcnt_d  = 4'd0;
          end
        end else begin
          icnt_d = icnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (trig && cfg_en) begin
          state_d   = ST_CAPTURE;
          wcnt_d    = '0;
          pkt_cnt_d = '0;
          mode_d    = cfg_capture_mode;
          len_d     = cfg_data_length;
          gap_d     = cfg_gap;
          idle_d    = cfg_idle_length;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!cfg_en) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      gcnt_q    <= 4'd0;
      icnt_q    <= '0;
      pkt_cnt_q <= '0;
      mode_q    <= 1'b0;
      len_q     <= 2'b00;
      gap_q     <= 4'd0;
      idle_q    <= '0;
      pkt_vld_q <= 1'b0;
      pkt_sop_q <= 1'b0;
      pkt_eop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      gcnt_q    <= gcnt_d;
      icnt_q    <= icnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      pkt_vld_q <= pkt_vld_d;
      pkt_sop_q <= pkt_sop_d;
      pkt_eop_q <= pkt_eop_d;
    end
  end

  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wr_fire ? wcnt_q[AW-1:0] : '0;
  assign mem_wr_data = wr_fire ? adc_data : '0;
  assign mem_rd_en   = rd_fire;
  assign mem_rd_addr = rd_fire ? rcnt_q[AW-1:0] : '0;

  // Memory data arrives the cycle after the read, aligned with pkt_vld_q.
  assign pkt_vld  = pkt_vld_q;
  assign pkt_sop  = pkt_sop_q;
  assign pkt_eop  = pkt_eop_q;
  assign pkt_data = pkt_vld_q ? mem_rd_data : '0;

  assign busy    = (state_q == ST_CAPTURE) || (state_q == ST_SEND) || (state_q == ST_IDLE_GAP);
  assign done    = (state_q == ST_DONE);
  assign pkt_cnt = pkt_cnt_q;

endmodule
